// File: rtl/clm_sub_bytes_sched.sv
// Round scheduler for the masked AES sub-bytes stage: randomness load, S-box wait, linear-layer enable.
// Optional `ROUND_TIMEOUT_EN adds a SUB-state watchdog and the sticky err output.
module clm_sub_bytes_sched #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned R_REFRESH  = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       rnd_req,
  input  logic       rnd_vld,
  output logic       sb_active,
  output logic       sb_load_r,
  input  logic       sb_drdy,
  output logic       lin_en,
  output logic       last_round,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done
`ifdef ROUND_TIMEOUT_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_R,
    LOAD_R,
    SUB,
    LIN,
    DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] RR   = 4'(R_REFRESH);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] rfr_q, rfr_d;

`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rfr_d   = rfr_q;
`ifdef ROUND_TIMEOUT_EN
    tmo   = 1'b0;
    // Zero outside SUB, so the first SUB cycle always sees a cleared count.
    cnt_d = (state_q == SUB) ? cnt_q + CW'(1) : '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ_R;
          round_d = '0;
          rfr_d   = '0;
        end
      end
      REQ_R:  if (rnd_vld) state_d = LOAD_R;
      LOAD_R: state_d = SUB;
      SUB: begin
        if (sb_drdy) begin
          state_d = LIN;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
`endif
      end
      LIN: begin
        if (round_q == LAST) begin
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
          if (R_REFRESH != 0 && (rfr_q + 4'd1) == RR) begin
            rfr_d   = '0;
            state_d = REQ_R;
          end else begin
            rfr_d   = rfr_q + 4'd1;
            state_d = SUB;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      round_q   <= '0;
      rfr_q     <= '0;
      rnd_req   <= 1'b0;
      sb_active <= 1'b0;
      sb_load_r <= 1'b0;
      lin_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      cnt_q     <= '0;
      err       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      rfr_q     <= rfr_d;
      rnd_req   <= (state_d == REQ_R);
      sb_active <= (state_d == LOAD_R) || (state_d == SUB);
      sb_load_r <= (state_d == LOAD_R);
      lin_en    <= (state_d == LIN);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
`ifdef ROUND_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err       <= err | tmo;
`endif
    end
  end

  assign round_idx  = round_q;
  assign last_round = (round_q == LAST);

endmodule
